subtrator_serial: RTL

- Bit-serial sequential subtractor. Computes s = a - b for WIDTH-bit operands, one bit per clock, LSB first.
- Serves as the inverse-direction companion to the team's combinational 4-bit adder, using the same operand/result naming (a_i, b_i, s_o, borrow out in place of carry out).
- Sits behind a start/done handshake so a controller can launch operations and collect results.
- Targets area-constrained paths where a full-width ripple subtractor is not wanted.

---
 rtl/subtrator_serial.sv | 119 +++++++++++
 1 files changed

// File: rtl/subtrator_serial.sv
// rtl/subtrator_serial.sv - bit-serial LSB-first subtractor (s = a - b) behind a start/done handshake
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset
//   start_i  in   launch request, honoured only while busy_o=0
//   a_i      in   [WIDTH-1:0] minuend, captured on an accepted start
//   b_i      in   [WIDTH-1:0] subtrahend, captured on an accepted start
//   busy_o   out  high while bits are being processed (RUN)
//   done_o   out  one-cycle pulse when s_o/bo_o carry a fresh result
//   s_o      out  [WIDTH-1:0] (a - b) mod 2^WIDTH, held until the next result
//   bo_o     out  borrow out, 1 when a < b unsigned
//   ovf_o    out  two's-complement overflow, only when SUBTRATOR_SERIAL_OVF_EN is defined
module subtrator_serial #(
  parameter int  WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             bo_o
`ifdef SUBTRATOR_SERIAL_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh, b_sh;
  // Holds the WIDTH-1 difference bits produced so far; the final bit is
  // merged in combinationally when the result is committed.
  logic [WIDTH-2:0]   r_sh;
  logic [CNT_W-1:0]   cnt;
  logic               br;
  logic [WIDTH-1:0]   s_q;
  logic               bo_q;

  logic               ak, bk, d, br_n, last, accept;
  logic [WIDTH-1:0]   r_next;

  always_comb begin
    state_d = state_q;
    ak      = a_sh[0];
    bk      = b_sh[0];
    d       = ak ^ bk ^ br;
    br_n    = (~ak & bk) | (~(ak ^ bk) & br);
    r_next  = {d, r_sh};
    last    = (cnt == CNT_W'(WIDTH - 1));
    // DONE may relaunch directly, so a start is honoured in any non-RUN state.
    accept  = start_i && (state_q != RUN);
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = start_i ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      cnt  <= '0;
      br   <= 1'b0;
      s_q  <= '0;
      bo_q <= 1'b0;
    end else if (accept) begin
      a_sh <= a_i;
      b_sh <= b_i;
      cnt  <= '0;
      br   <= 1'b0;
    end else if (state_q == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      r_sh <= r_next[WIDTH-1:1];
      cnt  <= cnt + CNT_W'(1);
      br   <= br_n;
      if (last) begin
        s_q  <= r_next;
        bo_q <= br_n;
      end
    end
  end

`ifdef SUBTRATOR_SERIAL_OVF_EN
  logic ovf_q;

  // On the MSB step br is the borrow into the sign bit and br_n the borrow out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                  ovf_q <= 1'b0;
    else if (!accept && state_q == RUN && last)   ovf_q <= br ^ br_n;
  end

  assign ovf_o = ovf_q;
`endif

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);
  assign s_o    = s_q;
  assign bo_o   = bo_q;

endmodule
